// File: rtl/lisa_spi_pkg.sv
// Shared SPI definitions for the LISA target and initiator: opcodes, FSM states
// and the address wrap helper.
package lisa_spi_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_QREAD = 8'hEB;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD,
    ST_WR,
    ST_IGNORE
  } spi_state_e;

  // Byte address confined to the active address width.
  function automatic logic [23:0] wrap_addr(input logic [23:0] a, input logic is_16b);
    return is_16b ? {8'h00, a[15:0]} : a;
  endfunction

endpackage

// File: rtl/lisa_spi_sync.sv
// Two-flop synchronisers for the SPI pins plus sclk and ce_n edge detection
// on the synchronised signals.
module lisa_spi_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       ce_n_i,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_s,
  output logic       ce_n_s,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       ce_fall,
  output logic       ce_rise
);

  logic [1:0] sclk_ff;
  logic [1:0] ce_ff;
  logic [3:0] sio_ff1;
  logic [3:0] sio_ff2;
  logic       sclk_d;
  logic       ce_d;
  logic [1:0] hi_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_ff <= 2'b00;
      ce_ff   <= 2'b11;
      sio_ff1 <= 4'h0;
      sio_ff2 <= 4'h0;
      sclk_d  <= 1'b0;
      ce_d    <= 1'b1;
      hi_cnt  <= 2'd0;
    end else begin
      sclk_ff <= {sclk_ff[0], sclk_i};
      ce_ff   <= {ce_ff[0], ce_n_i};
      sio_ff1 <= sio_i;
      sio_ff2 <= sio_ff1;
      sclk_d  <= sclk_ff[1];
      ce_d    <= ce_ff[1];
      hi_cnt  <= !ce_ff[1] ? 2'd0 : ((hi_cnt == 2'd3) ? 2'd3 : hi_cnt + 2'd1);
    end
  end

  assign sio_s     = sio_ff2;
  assign ce_n_s    = ce_ff[1];
  assign sclk_rise = sclk_ff[1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[1] & sclk_d;
  assign ce_rise   = ce_ff[1] & ~ce_d;
  // A fall only counts after ce_n has been seen high for a while, so the idle
  // level forced by reset cannot fake a chip select on a bus already held low.
  assign ce_fall   = ce_d & ~ce_ff[1] & (hi_cnt == 2'd3);

endmodule

// File: rtl/lisa_spi_target.sv
// SPI mode-0 memory target: single/quad command, address, dummy, read stream
// and write phases driving a simple byte-wide memory port.
module lisa_spi_target
  import lisa_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk_i,
  input  logic        ce_n_i,
  input  logic [3:0]  sio_i,
  output logic [3:0]  sio_o,
  output logic [3:0]  sio_oe,
  input  logic        addr_16b,
  input  logic [3:0]  dummy_cycles,
  input  logic [7:0]  cmd_quad_write,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        cmd_err,
  input  logic        err_clr
);

  logic [3:0] sio_s;
  logic       ce_n_s, sclk_rise, sclk_fall, ce_fall, ce_rise;

  lisa_spi_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk_i    (sclk_i),
    .ce_n_i    (ce_n_i),
    .sio_i     (sio_i),
    .sio_s     (sio_s),
    .ce_n_s    (ce_n_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ce_fall   (ce_fall),
    .ce_rise   (ce_rise)
  );

  spi_state_e  state_reg, state_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  cmd_reg, cmd_next;
  logic        quad_reg, quad_next;
  logic [23:0] addr_reg, addr_next;
  logic [7:0]  shift_reg, shift_next;
  logic [3:0]  sio_o_reg, sio_o_next;
  logic [23:0] mem_addr_reg, mem_addr_next;
  logic [7:0]  mem_wdata_reg, mem_wdata_next;
  logic        mem_we_reg, mem_we_next;
  logic        mem_re_reg, mem_re_next;
  logic        re_d_reg;
  logic        cmd_err_reg, cmd_err_next;

  logic [7:0]  cmd_shift, byte_shift;
  logic [23:0] addr_shift, addr_done, addr_inc;
  logic [4:0]  byte_len;
  logic        last_bit;
  logic        err_set;

  assign cmd_shift  = {cmd_reg[6:0], sio_s[0]};
  assign byte_shift = quad_reg ? {shift_reg[3:0], sio_s} : {shift_reg[6:0], sio_s[0]};
  assign addr_shift = quad_reg ? {addr_reg[19:0], sio_s} : {addr_reg[22:0], sio_s[0]};
  assign addr_done  = wrap_addr(addr_shift, addr_16b);
  assign addr_inc   = wrap_addr(addr_reg + 24'd1, addr_16b);
  assign byte_len   = quad_reg ? 5'd2 : 5'd8;
  assign last_bit   = (bit_cnt_reg == 5'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 5'd0;
      cmd_reg       <= 8'h00;
      quad_reg      <= 1'b0;
      addr_reg      <= 24'h0;
      shift_reg     <= 8'h00;
      sio_o_reg     <= 4'h0;
      mem_addr_reg  <= 24'h0;
      mem_wdata_reg <= 8'h00;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      re_d_reg      <= 1'b0;
      cmd_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      cmd_reg       <= cmd_next;
      quad_reg      <= quad_next;
      addr_reg      <= addr_next;
      shift_reg     <= shift_next;
      sio_o_reg     <= sio_o_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_we_reg    <= mem_we_next;
      mem_re_reg    <= mem_re_next;
      re_d_reg      <= mem_re_reg;
      cmd_err_reg   <= cmd_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    cmd_next       = cmd_reg;
    quad_next      = quad_reg;
    addr_next      = addr_reg;
    shift_next     = shift_reg;
    sio_o_next     = (state_reg == ST_RD) ? sio_o_reg : 4'h0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_we_next    = 1'b0;
    mem_re_next    = 1'b0;
    err_set        = 1'b0;

    // Read data arrives one clk after the strobe and refills the shifter.
    if (re_d_reg && state_reg == ST_RD) shift_next = mem_rdata;

    case (state_reg)
      ST_IDLE: begin
        if (ce_fall) begin
          state_next   = ST_CMD;
          bit_cnt_next = 5'd8;
          cmd_next     = 8'h00;
          addr_next    = 24'h0;
          quad_next    = 1'b0;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          cmd_next     = cmd_shift;
          bit_cnt_next = bit_cnt_reg - 5'd1;
          if (last_bit) begin
            if (cmd_shift == OP_READ || cmd_shift == OP_WRITE) begin
              state_next   = ST_ADDR;
              quad_next    = 1'b0;
              bit_cnt_next = addr_16b ? 5'd16 : 5'd24;
            end else if (cmd_shift == OP_QREAD || cmd_shift == cmd_quad_write) begin
              state_next   = ST_ADDR;
              quad_next    = 1'b1;
              bit_cnt_next = addr_16b ? 5'd4 : 5'd6;
            end else begin
              state_next = ST_IGNORE;
              err_set    = (cmd_shift != OP_WREN);
            end
          end
        end
      end
      ST_ADDR: begin
        if (sclk_rise) begin
          addr_next    = addr_shift;
          bit_cnt_next = bit_cnt_reg - 5'd1;
          if (last_bit) begin
            addr_next = addr_done;
            if (cmd_reg == OP_QREAD && dummy_cycles != 4'd0) begin
              state_next   = ST_DUMMY;
              bit_cnt_next = {1'b0, dummy_cycles};
            end else if (cmd_reg == OP_READ || cmd_reg == OP_QREAD) begin
              state_next    = ST_RD;
              mem_re_next   = 1'b1;
              mem_addr_next = addr_done;
              bit_cnt_next  = byte_len;
            end else begin
              state_next   = ST_WR;
              bit_cnt_next = byte_len;
            end
          end
        end
      end
      ST_DUMMY: begin
        if (sclk_rise) begin
          bit_cnt_next = bit_cnt_reg - 5'd1;
          if (last_bit) begin
            state_next    = ST_RD;
            mem_re_next   = 1'b1;
            mem_addr_next = addr_reg;
            bit_cnt_next  = byte_len;
          end
        end
      end
      ST_RD: begin
        if (sclk_fall) begin
          if (quad_reg) begin
            sio_o_next = shift_reg[7:4];
            shift_next = {shift_reg[3:0], 4'h0};
          end else begin
            sio_o_next = {2'b00, shift_reg[7], 1'b0};
            shift_next = {shift_reg[6:0], 1'b0};
          end
        end
        // Fetch the next byte as soon as the last unit of this one is sampled.
        if (sclk_rise) begin
          bit_cnt_next = bit_cnt_reg - 5'd1;
          if (last_bit) begin
            addr_next     = addr_inc;
            mem_re_next   = 1'b1;
            mem_addr_next = addr_inc;
            bit_cnt_next  = byte_len;
          end
        end
      end
      ST_WR: begin
        if (sclk_rise) begin
          shift_next   = byte_shift;
          bit_cnt_next = bit_cnt_reg - 5'd1;
          if (last_bit) begin
            mem_wdata_next = byte_shift;
            mem_we_next    = 1'b1;
            mem_addr_next  = addr_reg;
            addr_next      = addr_inc;
            bit_cnt_next   = byte_len;
          end
        end
      end
      default: ;
    endcase

    if (ce_rise) begin
      state_next  = ST_IDLE;
      sio_o_next  = 4'h0;
      mem_we_next = 1'b0;
      mem_re_next = 1'b0;
    end

    cmd_err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : cmd_err_reg);
  end

  assign sio_o     = sio_o_reg;
  assign sio_oe    = (state_reg == ST_RD) ? (quad_reg ? 4'hF : 4'b0010) : 4'h0;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_we    = mem_we_reg;
  assign mem_re    = mem_re_reg;
  assign busy      = ~ce_n_s;
  assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_lisa_spi_target.sv
// Directed bench for lisa_spi_target: SPI initiator tasks, byte memory model
// and per-scenario checks.
module tb_lisa_spi_target;
  import lisa_spi_pkg::*;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk_i = 1'b0;
  logic        ce_n_i = 1'b1;
  logic [3:0]  sio_i = 4'h0;
  logic [3:0]  sio_o, sio_oe;
  logic        addr_16b = 1'b0;
  logic [3:0]  dummy_cycles = 4'd0;
  logic [7:0]  cmd_quad_write = 8'h38;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy, cmd_err;
  logic        err_clr = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem_model [int];
  logic [23:0] re_log [$];
  logic [23:0] we_addr_log [$];
  logic [7:0]  we_data_log [$];
  bit          both_seen = 1'b0;

  always #5 clk = ~clk;

  lisa_spi_target dut (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .ce_n_i(ce_n_i), .sio_i(sio_i),
    .sio_o(sio_o), .sio_oe(sio_oe), .addr_16b(addr_16b), .dummy_cycles(dummy_cycles),
    .cmd_quad_write(cmd_quad_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy),
    .cmd_err(cmd_err), .err_clr(err_clr)
  );

  // Byte memory with one-clk read latency; logs every strobe.
  always @(posedge clk) begin
    if (mem_re) begin
      re_log.push_back(mem_addr);
      mem_rdata <= mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 8'h00;
    end
    if (mem_we) begin
      we_addr_log.push_back(mem_addr);
      we_data_log.push_back(mem_wdata);
    end
    if (mem_we && mem_re) both_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sclk_cycle(input logic [3:0] d, output logic [3:0] q);
    sio_i = d;
    repeat (HALF) @(negedge clk);
    q = sio_o;
    sclk_i = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk_i = 1'b0;
  endtask

  task automatic send_single(input logic [7:0] b);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, b[i]}, q);
  endtask

  task automatic send_nib(input logic [3:0] n);
    logic [3:0] q;
    sclk_cycle(n, q);
  endtask

  task automatic read_single(output logic [7:0] b);
    logic [3:0] q;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sclk_cycle(4'h0, q);
      b = {b[6:0], q[1]};
    end
  endtask

  task automatic read_quad(output logic [7:0] b);
    logic [3:0] q1, q2;
    sclk_cycle(4'h0, q1);
    sclk_cycle(4'h0, q2);
    b = {q1, q2};
  endtask

  task automatic select_dev();
    ce_n_i = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic deselect_dev();
    repeat (HALF) @(negedge clk);
    ce_n_i = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic clear_logs();
    re_log.delete();
    we_addr_log.delete();
    we_data_log.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sio_o !== 4'h0) begin bad++; $display("FAIL rst_sio_o: got %h want 0", sio_o); end
    total++; if (sio_oe !== 4'h0) begin bad++; $display("FAIL rst_sio_oe: got %h want 0", sio_oe); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL rst_mem_re: got %b want 0", mem_re); end
    total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    total++; if (mem_wdata !== 8'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_single_read();
    logic [7:0] b0, b1;
    addr_16b = 1'b0;
    clear_logs();
    select_dev();
    send_single(OP_READ);
    send_single(8'h00); send_single(8'h01); send_single(8'h00);
    read_single(b0);
    read_single(b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL srd_busy: got %b want 1", busy); end
    total++; if (sio_oe !== 4'b0010) begin bad++; $display("FAIL srd_sio_oe: got %h want 2", sio_oe); end
    deselect_dev();
    $display("txn single_read addr=000100 data=%h %h", b0, b1);
    total++; if (b0 !== 8'hA5) begin bad++; $display("FAIL srd_byte0: got %h want a5", b0); end
    total++; if (b1 !== 8'h3C) begin bad++; $display("FAIL srd_byte1: got %h want 3c", b1); end
    total++; if (re_log.size() < 2) begin bad++; $display("FAIL srd_re_count: got %0d want >=2", re_log.size()); end
    else begin
      total++; if (re_log[0] !== 24'h000100) begin bad++; $display("FAIL srd_re_addr0: got %h want 000100", re_log[0]); end
      total++; if (re_log[1] !== 24'h000101) begin bad++; $display("FAIL srd_re_addr1: got %h want 000101", re_log[1]); end
    end
    total++; if (we_addr_log.size() != 0) begin bad++; $display("FAIL srd_no_we: got %0d want 0", we_addr_log.size()); end
    total++; if (sio_oe !== 4'h0) begin bad++; $display("FAIL srd_oe_after: got %h want 0", sio_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL srd_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_quad_read();
    logic [7:0] b0, b1;
    logic [3:0] q;
    addr_16b = 1'b0;
    dummy_cycles = 4'd6;
    clear_logs();
    select_dev();
    send_single(OP_QREAD);
    send_nib(4'h1); send_nib(4'h2); send_nib(4'h3); send_nib(4'h4); send_nib(4'h5); send_nib(4'h6);
    for (int i = 0; i < 6; i++) sclk_cycle(4'h0, q);
    read_quad(b0);
    total++; if (sio_oe !== 4'hF) begin bad++; $display("FAIL qrd_sio_oe: got %h want f", sio_oe); end
    read_quad(b1);
    deselect_dev();
    $display("txn quad_read addr=123456 nibbles=%h %h %h %h", b0[7:4], b0[3:0], b1[7:4], b1[3:0]);
    total++; if (b0 !== 8'hA5) begin bad++; $display("FAIL qrd_byte0: got %h want a5", b0); end
    total++; if (b1 !== 8'h3C) begin bad++; $display("FAIL qrd_byte1: got %h want 3c", b1); end
    total++; if (re_log.size() < 2) begin bad++; $display("FAIL qrd_re_count: got %0d want >=2", re_log.size()); end
    else begin
      total++; if (re_log[0] !== 24'h123456) begin bad++; $display("FAIL qrd_re_addr0: got %h want 123456", re_log[0]); end
      total++; if (re_log[1] !== 24'h123457) begin bad++; $display("FAIL qrd_re_addr1: got %h want 123457", re_log[1]); end
    end
  endtask

  task automatic test_quad_write_wrap();
    addr_16b = 1'b1;
    cmd_quad_write = 8'h38;
    clear_logs();
    select_dev();
    send_single(8'h38);
    send_nib(4'hF); send_nib(4'hF); send_nib(4'hF); send_nib(4'hF);
    send_nib(4'h1); send_nib(4'h1);
    send_nib(4'h2); send_nib(4'h2);
    deselect_dev();
    $display("txn quad_write addr=ffff writes=%0d", we_addr_log.size());
    total++; if (we_addr_log.size() != 2) begin bad++; $display("FAIL qwr_we_count: got %0d want 2", we_addr_log.size()); end
    else begin
      total++; if (we_addr_log[0] !== 24'h00FFFF) begin bad++; $display("FAIL qwr_addr0: got %h want 00ffff", we_addr_log[0]); end
      total++; if (we_data_log[0] !== 8'h11) begin bad++; $display("FAIL qwr_data0: got %h want 11", we_data_log[0]); end
      total++; if (we_addr_log[1] !== 24'h000000) begin bad++; $display("FAIL qwr_addr1: got %h want 000000", we_addr_log[1]); end
      total++; if (we_data_log[1] !== 8'h22) begin bad++; $display("FAIL qwr_data1: got %h want 22", we_data_log[1]); end
    end
    total++; if (re_log.size() != 0) begin bad++; $display("FAIL qwr_no_re: got %0d want 0", re_log.size()); end
    addr_16b = 1'b0;
  endtask

  task automatic test_abort_write();
    addr_16b = 1'b0;
    clear_logs();
    select_dev();
    send_single(OP_WRITE);
    send_single(8'h00); send_single(8'h00); send_single(8'h10);
    send_single(8'h5A);
    send_nib(4'h1); send_nib(4'h0); send_nib(4'h1); send_nib(4'h0);
    deselect_dev();
    $display("txn abort_write addr=000010 writes=%0d", we_addr_log.size());
    total++; if (we_addr_log.size() != 1) begin bad++; $display("FAIL abt_we_count: got %0d want 1", we_addr_log.size()); end
    else begin
      total++; if (we_addr_log[0] !== 24'h000010) begin bad++; $display("FAIL abt_addr: got %h want 000010", we_addr_log[0]); end
      total++; if (we_data_log[0] !== 8'h5A) begin bad++; $display("FAIL abt_data: got %h want 5a", we_data_log[0]); end
    end
    total++; if (sio_oe !== 4'h0) begin bad++; $display("FAIL abt_sio_oe: got %h want 0", sio_oe); end
    total++; if (dut.state_reg !== ST_IDLE) begin bad++; $display("FAIL abt_state: got %0d want %0d", dut.state_reg, ST_IDLE); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b0;
    clear_logs();
    select_dev();
    send_single(8'h9F);
    send_single(8'h00);
    deselect_dev();
    $display("txn bad_opcode op=9f cmd_err=%b", cmd_err);
    total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL bad_err_set: got %b want 1", cmd_err); end
    total++; if (re_log.size() + we_addr_log.size() != 0) begin bad++; $display("FAIL bad_no_strobe: got %0d want 0", re_log.size() + we_addr_log.size()); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL bad_err_clr: got %b want 0", cmd_err); end
    select_dev();
    send_single(OP_READ);
    send_single(8'h00); send_single(8'h01); send_single(8'h01);
    read_single(b0);
    deselect_dev();
    $display("txn read_after_err addr=000101 data=%h", b0);
    total++; if (b0 !== 8'h3C) begin bad++; $display("FAIL bad_next_read: got %h want 3c", b0); end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] q;
    logic [7:0] b0;
    select_dev();
    send_single(OP_READ);
    send_single(8'h00); send_single(8'h01); send_single(8'h00);
    for (int i = 0; i < 5; i++) sclk_cycle(4'h0, q);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (sio_o !== 4'h0) begin bad++; $display("FAIL mrst_sio_o: got %h want 0", sio_o); end
    total++; if (sio_oe !== 4'h0) begin bad++; $display("FAIL mrst_sio_oe: got %h want 0", sio_oe); end
    total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL mrst_mem_addr: got %h want 0", mem_addr); end
    total++; if (mem_wdata !== 8'h0) begin bad++; $display("FAIL mrst_mem_wdata: got %h want 0", mem_wdata); end
    total++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL mrst_strobes: got re=%b we=%b want 0", mem_re, mem_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 16; i++) sclk_cycle(4'h1, q);
    total++; if (re_log.size() + we_addr_log.size() != 0) begin bad++; $display("FAIL mrst_no_resume: got %0d want 0", re_log.size() + we_addr_log.size()); end
    total++; if (dut.state_reg !== ST_IDLE) begin bad++; $display("FAIL mrst_state: got %0d want %0d", dut.state_reg, ST_IDLE); end
    deselect_dev();
    select_dev();
    send_single(OP_READ);
    send_single(8'h00); send_single(8'h01); send_single(8'h00);
    read_single(b0);
    deselect_dev();
    $display("txn read_after_reset addr=000100 data=%h", b0);
    total++; if (b0 !== 8'hA5) begin bad++; $display("FAIL mrst_next_read: got %h want a5", b0); end
  endtask

  task automatic test_exclusive();
    total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL strobe_overlap: got %b want 0", both_seen); end
  endtask

  initial begin
    mem_model[32'h000100] = 8'hA5;
    mem_model[32'h000101] = 8'h3C;
    mem_model[32'h123456] = 8'hA5;
    mem_model[32'h123457] = 8'h3C;
    test_reset();
    test_single_read();
    test_quad_read();
    test_quad_write_wrap();
    test_abort_write();
    test_bad_opcode();
    test_reset_mid_read();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
